rgb_fade_engine: RTL and testbench
==================================

// Module: rgb_fade_engine
// PURPOSE
// - N-channel hue-wheel fade engine: generates phase-offset triangle duty profiles (rise/hold-high/fall/hold-low)
//   for every LED channel, applies global brightness and mode, and drives glitch-free PWM outputs directly.
// - Successor to the single-colour fade block: parametrised channel count, absolute (drift-free) duty,
//   enable/hold, mode select, brightness scaling and integrated PWM. Sits between top level and the LED pins.
// PARAMETERS
// - N_CHANNELS       3      number of LED channels (>=1)
// - PWM_PERIOD       1200   clocks per PWM period (100 us @ 12 MHz)
// - STEP_INTERVAL    12000  clocks per duty step (1 ms)
// - STEPS_PER_PHASE  167    duty steps per phase
// - STEP_AMOUNT      PWM_PERIOD/STEPS_PER_PHASE  duty increment per step
// - DUTY_W           $clog2(PWM_PERIOD)  duty width
// PORTS
// - clk           in   1               system clock
// - rst_n         in   1               asynchronous reset, active low
// - i_enable      in   1               1 = fade advances; 0 = freeze step/phase counters (PWM keeps running)
// - i_mode        in   2               0 FADE, 1 SOLID_ON (duty=PWM_PERIOD-1), 2 OFF (duty=0), 3 reserved = FADE
// - i_brightness  in   8               global scale; eff = (duty*(brightness+1))>>8
// - o_pwm         out  N_CHANNELS      PWM outputs, bit k = channel k
// - o_duty        out  N_CHANNELS*DUTY_W  effective duty per channel, channel k at [k*DUTY_W +: DUTY_W]
// - o_period_strobe out 1              1-clock pulse on the last clock of every PWM period
// BEHAVIOUR
// - Reset (async, rst_n=0): all counters 0, o_pwm=0, o_duty=0, o_period_strobe=0; channel k phase=(2+4k) mod 6.
// - Phases (cyclic): INC(0)->HIGH1(1)->HIGH2(2)->DEC(3)->LOW1(4)->LOW2(5)->INC. Ch0/1/2 reset to HIGH2/INC/LOW1.
// - Prescaler: step_cnt 0..STEP_INTERVAL-1, runs only while i_enable; step_tick on terminal count.
// - Per step_tick: step_idx 0..STEPS_PER_PHASE-1; at terminal, step_idx->0 and every channel phase advances
//   in the same cycle. step_idx shared by all channels (channels stay locked).
// - Raw duty (combinational from phase/step_idx, never accumulated):
//   INC: step_idx*STEP_AMOUNT; DEC: (STEPS_PER_PHASE-1-step_idx)*STEP_AMOUNT; HIGH: PWM_PERIOD-1; LOW: 0.
//   Products clamp to PWM_PERIOD-1.
// - Mode override applied after raw duty, before brightness. brightness=255 -> eff==duty exactly; 0 -> duty>>8.
// - PWM: pwm_cnt 0..PWM_PERIOD-1, always running out of reset regardless of i_enable.
//   Effective duty latched into shadow register only when pwm_cnt==PWM_PERIOD-1 (same cycle as strobe);
//   o_duty shows shadow value. o_pwm[k] registered = (pwm_cnt < shadow[k]); duty 0 -> constant low,
//   PWM_PERIOD-1 -> low exactly 1 clock per period. Mode/brightness/step changes therefore never glitch mid-period.
// - Latency: input change -> o_duty at next period boundary (<=PWM_PERIOD clocks); o_pwm 1 clock after pwm_cnt.
// - i_enable falling: step_cnt/step_idx/phase hold exactly; rising: resume from held values, no skipped tick.
// - Simultaneous step terminal and PWM boundary: shadow captures duty computed from pre-update step state.
// - Reset mid-operation: immediate async clear of all state and outputs; restart from reset phases.
// STRUCTURE
// - Package rgb_fade_pkg: phase_t enum (6 values above), mode_t enum, phase_next() function, RESET_PHASE(k).
// - Sub-module fade_channel (one per channel, generate loop): holds phase, computes raw/mode/scaled duty,
//   shadow register and o_pwm bit. Top holds prescaler, step_idx, pwm_cnt, strobe.
// TESTING (sim params: PWM_PERIOD=16, STEP_INTERVAL=4, STEPS_PER_PHASE=4, STEP_AMOUNT=4, N_CHANNELS=3)
// - Reset release, mode FADE, bright=255 -> first strobe: o_duty ch0=15, ch1=0, ch2=0; o_pwm=3'b000 then ch0 high 15/16.
// - Run 16 steps -> ch1 INC sequence 0,4,8,12 then HIGH 15; ch0 DEC 12,8,4,0; all phases wrap after 6*4 steps.
// - i_enable=0 for 100 clocks mid-INC (duty 8) -> o_duty stays 8, PWM continues 8/16; re-enable -> 12 after 4 clocks.
// - i_mode SOLID_ON mid-period -> o_pwm unchanged until strobe, then all channels 15; OFF -> all 0 and o_pwm=0.
// - bright=127, ch0 duty 15 -> o_duty=7; bright=0 -> 0.
// - Assert rst_n=0 mid-period with o_pwm high -> o_pwm=0 same cycle (async); release -> reset phases restored.

Source files
------------

// File: rtl/rgb_fade_pkg.sv
// Shared types and helpers for the hue-wheel fade engine.
package rgb_fade_pkg;

  localparam int unsigned NUM_PHASES = 6;

  // Triangle profile: rise, hold high twice, fall, hold low twice.
  typedef enum logic [2:0] {
    PH_INC   = 3'd0,
    PH_HIGH1 = 3'd1,
    PH_HIGH2 = 3'd2,
    PH_DEC   = 3'd3,
    PH_LOW1  = 3'd4,
    PH_LOW2  = 3'd5
  } phase_t;

  // Reserved encoding behaves as FADE.
  typedef enum logic [1:0] {
    MODE_FADE     = 2'd0,
    MODE_SOLID_ON = 2'd1,
    MODE_OFF      = 2'd2,
    MODE_RSVD     = 2'd3
  } mode_t;

  function automatic phase_t phase_next(input phase_t p);
    case (p)
      PH_INC:   return PH_HIGH1;
      PH_HIGH1: return PH_HIGH2;
      PH_HIGH2: return PH_DEC;
      PH_DEC:   return PH_LOW1;
      PH_LOW1:  return PH_LOW2;
      default:  return PH_INC;
    endcase
  endfunction

  // Channels are spaced two phases apart around the wheel (120 degrees).
  function automatic phase_t RESET_PHASE(input int unsigned k);
    return phase_t'(3'((2 + 4 * k) % NUM_PHASES));
  endfunction

endpackage

// File: rtl/rgb_fade_engine_channel.sv
// One LED channel: phase sequencer, duty shaping, period shadow and PWM bit.
module fade_channel
  import rgb_fade_pkg::*;
#(
  parameter int unsigned CH_INDEX        = 0,
  parameter int unsigned PWM_PERIOD      = 1200,
  parameter int unsigned STEPS_PER_PHASE = 167,
  parameter int unsigned STEP_AMOUNT     = PWM_PERIOD / STEPS_PER_PHASE,
  parameter int unsigned DUTY_W          = $clog2(PWM_PERIOD),
  parameter int unsigned SI_W            = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_phase_adv,
  input  logic [SI_W-1:0]   i_step_idx,
  input  logic [1:0]        i_mode,
  input  logic [7:0]        i_brightness,
  input  logic              i_load,
  input  logic [DUTY_W-1:0] i_pwm_cnt,
  output logic              o_pwm,
  output logic [DUTY_W-1:0] o_duty
);

  localparam logic [DUTY_W-1:0] DUTY_MAX = DUTY_W'(PWM_PERIOD - 1);

  phase_t              r_phase;
  phase_t              w_phase_next;
  logic [31:0]         w_prod;
  logic [DUTY_W-1:0]   w_raw;
  logic [DUTY_W-1:0]   w_moded;
  logic [DUTY_W+7:0]   w_scaled;
  logic [DUTY_W-1:0]   w_eff;
  logic [DUTY_W-1:0]   r_shadow;
  logic                r_pwm;

  // Next phase: advance only on the shared phase-wrap pulse.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    w_phase_next = r_phase;
    if (i_phase_adv) w_phase_next = phase_next(r_phase);
  end

  // Phase register; each channel starts at its own wheel offset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_phase <= RESET_PHASE(CH_INDEX);
    // NOTE: state registers use non-blocking assignment so all flops update from pre-edge values.
    else        r_phase <= w_phase_next;
  end

  // Raw duty is recomputed from phase/step every cycle, so it can never drift.
  always_comb begin
    w_prod = 32'd0;
    case (r_phase)
      PH_INC:             w_prod = 32'(i_step_idx) * STEP_AMOUNT;
      PH_DEC:             w_prod = (STEPS_PER_PHASE - 1 - 32'(i_step_idx)) * STEP_AMOUNT;
      PH_HIGH1, PH_HIGH2: w_prod = 32'(PWM_PERIOD - 1);
      default:            w_prod = 32'd0;
    endcase
    w_raw = (w_prod > 32'(PWM_PERIOD - 1)) ? DUTY_MAX : DUTY_W'(w_prod);
  end

  // Mode override, then brightness scale: eff = duty*(b+1)/256 (b=255 is exact).
  always_comb begin
    case (mode_t'(i_mode))
      MODE_SOLID_ON: w_moded = DUTY_MAX;
      MODE_OFF:      w_moded = '0;
      default:       w_moded = w_raw;
    endcase
    w_scaled = (DUTY_W + 8)'(w_moded) * (DUTY_W + 8)'({1'b0, i_brightness} + 9'd1);
    w_eff    = DUTY_W'(w_scaled >> 8);
  end

  // Shadow only reloads on the last clock of a period, keeping each period glitch-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_shadow <= '0;
    else if (i_load) r_shadow <= w_eff;
  end

  // Registered compare; at pwm_cnt==PERIOD-1 the output is always low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_pwm <= 1'b0;
    else        r_pwm <= (i_pwm_cnt < r_shadow);
  end

  assign o_pwm  = r_pwm;
  assign o_duty = r_shadow;

endmodule

// File: rtl/rgb_fade_engine.sv
// N-channel hue-wheel fade engine with integrated PWM.
// Holds the shared step prescaler, step index and PWM counter.
module rgb_fade_engine
  import rgb_fade_pkg::*;
#(
  parameter int unsigned N_CHANNELS      = 3,
  parameter int unsigned PWM_PERIOD      = 1200,
  parameter int unsigned STEP_INTERVAL   = 12000,
  parameter int unsigned STEPS_PER_PHASE = 167,
  parameter int unsigned STEP_AMOUNT     = PWM_PERIOD / STEPS_PER_PHASE,
  parameter int unsigned DUTY_W          = $clog2(PWM_PERIOD)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_enable,
  input  logic [1:0]                   i_mode,
  input  logic [7:0]                   i_brightness,
  output logic [N_CHANNELS-1:0]        o_pwm,
  output logic [N_CHANNELS*DUTY_W-1:0] o_duty,
  output logic                         o_period_strobe
);

  localparam int unsigned SC_W = (STEP_INTERVAL > 1) ? $clog2(STEP_INTERVAL) : 1;
  localparam int unsigned SI_W = (STEPS_PER_PHASE > 1) ? $clog2(STEPS_PER_PHASE) : 1;

  logic [SC_W-1:0]   r_step_cnt;
  logic [SI_W-1:0]   r_step_idx;
  logic [DUTY_W-1:0] r_pwm_cnt;
  logic              w_step_tick;
  logic              w_step_last;
  logic              w_phase_adv;
  logic              w_pwm_last;

  assign w_step_tick = i_enable && (r_step_cnt == SC_W'(STEP_INTERVAL - 1));
  assign w_step_last = (r_step_idx == SI_W'(STEPS_PER_PHASE - 1));
  assign w_phase_adv = w_step_tick && w_step_last;
  assign w_pwm_last  = (r_pwm_cnt == DUTY_W'(PWM_PERIOD - 1));

  // Step prescaler; frozen (not cleared) while disabled so resume skips nothing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_step_cnt <= '0;
    else if (i_enable) r_step_cnt <= w_step_tick ? '0 : r_step_cnt + 1'b1;
  end

  // Step index shared by all channels keeps them phase-locked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           r_step_idx <= '0;
    else if (w_step_tick) r_step_idx <= w_step_last ? '0 : r_step_idx + 1'b1;
  end

  // PWM period counter runs regardless of enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_pwm_cnt <= '0;
    else        r_pwm_cnt <= w_pwm_last ? '0 : r_pwm_cnt + 1'b1;
  end

  assign o_period_strobe = w_pwm_last;

  for (genvar k = 0; k < N_CHANNELS; k++) begin : g_ch
    fade_channel #(
      .CH_INDEX        (k),
      .PWM_PERIOD      (PWM_PERIOD),
      .STEPS_PER_PHASE (STEPS_PER_PHASE),
      .STEP_AMOUNT     (STEP_AMOUNT),
      .DUTY_W          (DUTY_W),
      .SI_W            (SI_W)
    ) u_ch (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_phase_adv  (w_phase_adv),
      .i_step_idx   (r_step_idx),
      .i_mode       (i_mode),
      .i_brightness (i_brightness),
      .i_load       (w_pwm_last),
      .i_pwm_cnt    (r_pwm_cnt),
      .o_pwm        (o_pwm[k]),
      .o_duty       (o_duty[k*DUTY_W +: DUTY_W])
    );
  end

endmodule

// File: tb/tb_rgb_fade_engine.sv
// Directed bench for rgb_fade_engine with small simulation parameters.
// o_duty is packed {ch2,ch1,ch0}, 4 bits each.
module tb_rgb_fade_engine;

  localparam int N  = 3;
  localparam int DW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_enable;
  logic [1:0]    i_mode;
  logic [7:0]    i_brightness;
  logic [N-1:0]  o_pwm;
  logic [N*DW-1:0] o_duty;
  logic          o_period_strobe;

  int n_total = 0;
  int n_pass  = 0;
  int h0, h1, h2;

  rgb_fade_engine #(
    .N_CHANNELS      (N),
    .PWM_PERIOD      (16),
    .STEP_INTERVAL   (4),
    .STEPS_PER_PHASE (4),
    .STEP_AMOUNT     (4),
    .DUTY_W          (DW)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_enable        (i_enable),
    .i_mode          (i_mode),
    .i_brightness    (i_brightness),
    .o_pwm           (o_pwm),
    .o_duty          (o_duty),
    .o_period_strobe (o_period_strobe)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Ends on a falling edge where the strobe is high (bounded).
  task automatic wait_strobe();
    int n = 0;
    while (o_period_strobe !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("strobe_seen", 32'(o_period_strobe), 32'd1);
  endtask

  // Ends on the falling edge just after a shadow reload.
  task automatic to_boundary();
    wait_strobe();
    @(negedge clk);
  endtask

  // Enable for exactly one prescaler interval -> exactly one step.
  task automatic step_once();
    i_enable = 1'b1;
    repeat (4) @(negedge clk);
    i_enable = 1'b0;
    to_boundary();
  endtask

  task automatic count_high(output int c0, output int c1, output int c2);
    c0 = 0; c1 = 0; c2 = 0;
    for (int i = 0; i < 16; i++) begin
      c0 += int'(o_pwm[0]);
      c1 += int'(o_pwm[1]);
      c2 += int'(o_pwm[2]);
      @(negedge clk);
    end
  endtask

  initial begin
    int n_strobe;
    logic [N*DW-1:0] exp_seq [8];
    exp_seq = '{12'h04F, 12'h08F, 12'h0CF, 12'h0FC, 12'h0F8, 12'h0F4, 12'h0F0, 12'h0F0};

    rst_n = 1'b0; i_enable = 1'b0; i_mode = 2'd0; i_brightness = 8'd255;
    repeat (3) @(negedge clk);
    check("rst_pwm", 32'(o_pwm), 32'd0);
    check("rst_duty", 32'(o_duty), 32'd0);
    check("rst_strobe", 32'(o_period_strobe), 32'd0);

    // Enable held low so the first capture sees step_idx 0: ch0 HIGH2, ch1 INC, ch2 LOW1.
    rst_n = 1'b1;
    wait_strobe();
    check("first_strobe_pwm", 32'(o_pwm), 32'd0);
    @(negedge clk);
    check("first_duty", 32'(o_duty), 32'h00F);
    count_high(h0, h1, h2);
    check("first_hi_ch0", 32'(h0), 32'd15);
    check("first_hi_ch1", 32'(h1), 32'd0);
    check("first_hi_ch2", 32'(h2), 32'd0);

    // Eight single steps: ch1 rises 4,8,12 then holds 15; ch0 falls 12,8,4,0.
    for (int s = 0; s < 8; s++) begin
      step_once();
      check($sformatf("step%0d_duty", s + 1), 32'(o_duty), 32'(exp_seq[s]));
    end

    // Remaining 16 steps complete 24 steps = full wheel, back to reset phases.
    i_enable = 1'b1;
    repeat (64) @(negedge clk);
    i_enable = 1'b0;
    to_boundary();
    check("wrap_duty", 32'(o_duty), 32'h00F);

    // Mid-INC at duty 8, then freeze halfway through a prescaler interval.
    step_once();
    step_once();
    check("inc8_duty", 32'(o_duty), 32'h08F);
    i_enable = 1'b1;
    repeat (2) @(negedge clk);
    i_enable = 1'b0;
    repeat (100) @(negedge clk);
    check("frozen_duty", 32'(o_duty), 32'h08F);
    count_high(h0, h1, h2);
    check("frozen_hi_ch1", 32'(h1), 32'd8);
    i_enable = 1'b1;
    repeat (2) @(negedge clk);
    i_enable = 1'b0;
    to_boundary();
    check("resume_duty", 32'(o_duty), 32'h0CF);

    // SOLID_ON applied mid-period must wait for the boundary.
    repeat (4) @(negedge clk);
    i_mode = 2'd1;
    @(negedge clk);
    check("solid_mid_pwm", 32'(o_pwm), 32'b011);
    check("solid_mid_duty", 32'(o_duty), 32'h0CF);
    to_boundary();
    check("solid_duty", 32'(o_duty), 32'hFFF);
    repeat (2) @(negedge clk);
    check("solid_pwm", 32'(o_pwm), 32'b111);

    i_mode = 2'd2;
    to_boundary();
    check("off_duty", 32'(o_duty), 32'h000);
    n_strobe = 0;
    for (int i = 0; i < 32; i++) begin
      check($sformatf("off_pwm_%0d", i), 32'(o_pwm), 32'd0);
      n_strobe += int'(o_period_strobe);
      @(negedge clk);
    end
    check("strobe_count", 32'(n_strobe), 32'd2);

    // Brightness: 15*128>>8=7, 12*128>>8=6; zero brightness -> 0.
    i_mode = 2'd0; i_brightness = 8'd127;
    to_boundary();
    check("bright127_duty", 32'(o_duty), 32'h067);
    i_brightness = 8'd0;
    to_boundary();
    check("bright0_duty", 32'(o_duty), 32'h000);
    i_mode = 2'd3; i_brightness = 8'd255;
    to_boundary();
    check("rsvd_mode_duty", 32'(o_duty), 32'h0CF);

    // Async reset while outputs are high.
    repeat (3) @(negedge clk);
    check("pre_reset_pwm", 32'(o_pwm), 32'b011);
    i_enable = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_pwm", 32'(o_pwm), 32'd0);
    check("async_rst_duty", 32'(o_duty), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    // Enabled from release: step terminal and period boundary coincide every 16 clocks,
    // so captures see pre-update state (reset phases at step 3, then one phase on).
    to_boundary();
    check("coincide1_duty", 32'(o_duty), 32'h0CF);
    to_boundary();
    check("coincide2_duty", 32'(o_duty), 32'h0F0);
    i_enable = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
